// File: rtl/hub75_pkg.sv
// HUB75 scan driver shared definitions.
// State encoding and pixel word field offsets.
package hub75_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOP,
    S_BOT,
    S_DATA,
    S_CLK,
    S_BLANK,
    S_LATCH,
    S_DISP
  } state_e;

  localparam int R_LSB = 8;
  localparam int G_LSB = 4;
  localparam int B_LSB = 0;

endpackage

// File: rtl/hub75_bcm_timer.sv
// Binary-coded-modulation display timer.
// Loads a cycle count and flags the final cycle.
module hub75_bcm_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] len,
  output logic          done
);

  logic [TW-1:0] cnt;

  // Down-counter: holds len on the first display cycle, 1 on the last
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (load)
      cnt <= len;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign done = (cnt == TW'(1));

endmodule

// File: rtl/hub75_scan_driver.sv
// HUB75 LED panel scan driver.
// Two-row shift, latch and BCM display per plane.
module hub75_scan_driver
  import hub75_pkg::*;
#(
  parameter int WIDTH     = 128,
  parameter int HEIGHT    = 64,
  parameter int BPP       = 12,
  parameter int BPC       = 4,
  parameter int CHAINED   = 1,
  parameter int DISP_BASE = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  output logic [13:0]                 addr,
  output logic                        re,
  input  logic [BPP-1:0]              dat_in,
  output logic                        r0,
  output logic                        g0,
  output logic                        b0,
  output logic                        r1,
  output logic                        g1,
  output logic                        b1,
  output logic                        sclk,
  output logic                        lat,
  output logic                        oe_n,
  output logic [$clog2(HEIGHT/2)-1:0] row_addr,
  output logic                        frame_done
);

  localparam int NCOL = CHAINED * WIDTH;
  localparam int HH   = HEIGHT / 2;
  localparam int CLW  = $clog2(NCOL);
  localparam int RW   = $clog2(HH);
  localparam int PW   = $clog2(BPC);
  localparam int TW   = $clog2(DISP_BASE << (BPC - 1)) + 1;

  state_e         state, nstate;
  logic [CLW-1:0] col, col_n;
  logic [RW-1:0]  row, row_n;
  logic [PW-1:0]  plane, plane_n;
  logic [BPP-1:0] top_px;
  logic           last_col, last_row, last_plane;
  logic           tload, tdone;
  logic [TW-1:0]  tlen;

  logic [13:0]    addr_d;
  logic           re_d, sclk_d, lat_d, oe_n_d, fd_d;
  logic [RW-1:0]  row_addr_d;
  logic [5:0]     rgb_q, rgb_d;

  logic [BPC-1:0] rt, gt, bt, rb, gb, bb;

  assign last_col   = (col == CLW'(NCOL - 1));
  assign last_row   = (row == RW'(HH - 1));
  assign last_plane = (plane == PW'(BPC - 1));

  assign tload = (state == S_LATCH);
  assign tlen  = TW'(DISP_BASE << plane);

  hub75_bcm_timer #(
    .TW(TW)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .load(tload),
    .len (tlen),
    .done(tdone)
  );

  // State and scan counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      col   <= '0;
      row   <= '0;
      plane <= '0;
    end else begin
      state <= nstate;
      col   <= col_n;
      row   <= row_n;
      plane <= plane_n;
    end
  end

  // Top pixel is on dat_in during BOT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      top_px <= '0;
    else if (state == S_BOT)
      top_px <= dat_in;
  end

  // Next state and next counter values
  always_comb begin
    nstate  = state;
    col_n   = col;
    row_n   = row;
    plane_n = plane;
    unique case (state)
      S_IDLE: begin
        col_n   = '0;
        row_n   = '0;
        plane_n = '0;
        if (en)
          nstate = S_TOP;
      end
      S_TOP:   nstate = S_BOT;
      S_BOT:   nstate = S_DATA;
      S_DATA:  nstate = S_CLK;
      S_CLK: begin
        if (last_col) begin
          nstate = S_BLANK;
        end else begin
          nstate = S_TOP;
          col_n  = col + 1'b1;
        end
      end
      S_BLANK: nstate = S_LATCH;
      S_LATCH: nstate = S_DISP;
      S_DISP: begin
        if (tdone) begin
          nstate = S_TOP;
          col_n  = '0;
          if (last_plane) begin
            plane_n = '0;
            if (last_row) begin
              row_n = '0;
              if (!en)
                nstate = S_IDLE;
            end else begin
              row_n = row + 1'b1;
            end
          end else begin
            plane_n = plane + 1'b1;
          end
        end
      end
      default: nstate = S_IDLE;
    endcase
  end

  // Colour bits of the current plane, top from register, bottom live
  always_comb begin
    rt = top_px[R_LSB +: BPC];
    gt = top_px[G_LSB +: BPC];
    bt = top_px[B_LSB +: BPC];
    rb = dat_in[R_LSB +: BPC];
    gb = dat_in[G_LSB +: BPC];
    bb = dat_in[B_LSB +: BPC];
  end

  // Output values for the state being entered
  always_comb begin
    addr_d     = addr;
    row_addr_d = row_addr;
    rgb_d      = rgb_q;
    re_d       = 1'b0;
    sclk_d     = (nstate == S_CLK);
    lat_d      = (nstate == S_LATCH);
    oe_n_d     = (nstate != S_DISP);
    fd_d       = (state == S_DISP) && tdone && last_plane && last_row;
    unique case (1'b1)
      (nstate == S_TOP): begin
        re_d   = 1'b1;
        addr_d = 14'((int'(row_n) * NCOL) + int'(col_n));
      end
      (nstate == S_BOT): begin
        re_d   = 1'b1;
        addr_d = 14'(((int'(row_n) + HH) * NCOL) + int'(col_n));
      end
      (nstate == S_LATCH): row_addr_d = row_n;
      (nstate == S_IDLE):  row_addr_d = '0;
      default: ;
    endcase
    if (state == S_DATA)
      rgb_d = {rt[plane], gt[plane], bt[plane],
               rb[plane], gb[plane], bb[plane]};
  end

  // Registered panel and framebuffer outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr       <= '0;
      re         <= 1'b0;
      sclk       <= 1'b0;
      lat        <= 1'b0;
      oe_n       <= 1'b1;
      row_addr   <= '0;
      frame_done <= 1'b0;
      rgb_q      <= '0;
    end else begin
      addr       <= addr_d;
      re         <= re_d;
      sclk       <= sclk_d;
      lat        <= lat_d;
      oe_n       <= oe_n_d;
      row_addr   <= row_addr_d;
      frame_done <= fd_d;
      rgb_q      <= rgb_d;
    end
  end

  assign {r0, g0, b0, r1, g1, b1} = rgb_q;

endmodule
